semaforo_temporizador: RTL and testbench

Timing initiator for the two-street traffic-light controller. Watches the controller's six lamp outputs and decodes the current phase. Counts a programmable dwell per phase and issues the one-cycle `pulso` that advances the controller. Also polices the lamp interface: it flags illegal lamp combinations, out-of-sequence phase changes and unanswered pulses, and then halts pulse generation until cleared.

---
 rtl/semaforo_temporizador.sv | 180 ++++++++++++++++++
 tb/tb_semaforo_temporizador.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/semaforo_temporizador.sv
// Dwell timer and lamp-interface watchdog for the two-street traffic-light controller.
// Decodes the observed lamps, times each phase, pulses the controller and halts on protocol errors.
module semaforo_temporizador #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned T_VERDE_2   = 50,
    parameter int unsigned T_AMARELO_2 = 10,
    parameter int unsigned T_VERDE_1   = 50,
    parameter int unsigned T_AMARELO_1 = 10,
    parameter int unsigned ACK_TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr_erro,
    input  logic       rua_1_vermelho,
    input  logic       rua_1_amarelo,
    input  logic       rua_1_verde,
    input  logic       rua_2_vermelho,
    input  logic       rua_2_amarelo,
    input  logic       rua_2_verde,
    output logic       pulso,
    output logic [1:0] fase,
    output logic       fase_valida,
    output logic       erro_comb,
    output logic       erro_timeout
);

    localparam int unsigned TO_W = $clog2(ACK_TIMEOUT + 1);

    // Last count value of each dwell; the pulse is issued on the cycle after it.
    localparam logic [CNT_W-1:0] FIM_0  = CNT_W'(T_VERDE_2 - 1);
    localparam logic [CNT_W-1:0] FIM_1  = CNT_W'(T_AMARELO_2 - 1);
    localparam logic [CNT_W-1:0] FIM_2  = CNT_W'(T_VERDE_1 - 1);
    localparam logic [CNT_W-1:0] FIM_3  = CNT_W'(T_AMARELO_1 - 1);
    localparam logic [TO_W-1:0]  TO_FIM = TO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONTA  = 2'd1,
        ESPERA = 2'd2,
        FALHA  = 2'd3
    } estado_t;

    estado_t          estado, estado_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [TO_W-1:0]  tcnt, tcnt_n;
    logic [1:0]       fase_n;
    logic             pulso_n;
    logic             fase_valida_n;
    logic             erro_comb_n;
    logic             erro_timeout_n;

    logic [5:0]       lampadas;
    logic             legal;
    logic [1:0]       fase_dec;
    logic [1:0]       fase_seg;
    logic [CNT_W-1:0] fim;

    assign lampadas = {rua_1_vermelho, rua_1_amarelo, rua_1_verde,
                       rua_2_vermelho, rua_2_amarelo, rua_2_verde};
    assign fase_seg = fase + 2'd1;

    // Exactly two lamps on, in one of the four legal pairings.
    always_comb begin
        legal    = 1'b1;
        fase_dec = 2'd0;
        case (lampadas)
            6'b100_001: fase_dec = 2'd0;
            6'b100_010: fase_dec = 2'd1;
            6'b001_100: fase_dec = 2'd2;
            6'b010_100: fase_dec = 2'd3;
            default:    legal    = 1'b0;
        endcase
    end

    always_comb begin
        fim = FIM_0;
        case (fase)
            2'd0: fim = FIM_0;
            2'd1: fim = FIM_1;
            2'd2: fim = FIM_2;
            2'd3: fim = FIM_3;
            default: fim = FIM_0;
        endcase
    end

    always_comb begin
        estado_n       = estado;
        cnt_n          = cnt;
        tcnt_n         = tcnt;
        fase_n         = fase;
        pulso_n        = 1'b0;
        fase_valida_n  = fase_valida;
        erro_comb_n    = erro_comb;
        erro_timeout_n = erro_timeout;

        case (estado)
            IDLE: begin
                if (en && legal) begin
                    fase_n        = fase_dec;
                    fase_valida_n = 1'b1;
                    cnt_n         = '0;
                    estado_n      = CONTA;
                end
            end

            CONTA: begin
                // Lamp check wins over a pulse due in the same cycle.
                if (!legal || (fase_dec != fase)) begin
                    erro_comb_n   = 1'b1;
                    fase_valida_n = 1'b0;
                    estado_n      = FALHA;
                end else if (en) begin
                    if (cnt == fim) begin
                        pulso_n  = 1'b1;
                        tcnt_n   = '0;
                        estado_n = ESPERA;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end

            ESPERA: begin
                // An advance seen on the last allowed cycle still counts.
                if (legal && (fase_dec == fase_seg)) begin
                    fase_n   = fase_dec;
                    cnt_n    = '0;
                    estado_n = CONTA;
                end else if (!legal || (fase_dec != fase)) begin
                    erro_comb_n   = 1'b1;
                    fase_valida_n = 1'b0;
                    estado_n      = FALHA;
                end else if (en) begin
                    if (tcnt == TO_FIM) begin
                        erro_timeout_n = 1'b1;
                        fase_valida_n  = 1'b0;
                        estado_n       = FALHA;
                    end else begin
                        tcnt_n = tcnt + TO_W'(1);
                    end
                end
            end

            FALHA: begin
                fase_valida_n = 1'b0;
                if (clr_erro) begin
                    erro_comb_n    = 1'b0;
                    erro_timeout_n = 1'b0;
                    estado_n       = IDLE;
                end
            end

            default: estado_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado       <= IDLE;
            cnt          <= '0;
            tcnt         <= '0;
            fase         <= 2'd0;
            pulso        <= 1'b0;
            fase_valida  <= 1'b0;
            erro_comb    <= 1'b0;
            erro_timeout <= 1'b0;
        end else begin
            estado       <= estado_n;
            cnt          <= cnt_n;
            tcnt         <= tcnt_n;
            fase         <= fase_n;
            pulso        <= pulso_n;
            fase_valida  <= fase_valida_n;
            erro_comb    <= erro_comb_n;
            erro_timeout <= erro_timeout_n;
        end
    end

endmodule

// File: tb/tb_semaforo_temporizador.sv
// Scoreboard bench for semaforo_temporizador: stimulus queues expected pulses and output
// snapshots by cycle number; a negedge monitor pops and compares them.
module tb_semaforo_temporizador;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       clr_erro = 1'b0;
    logic       pulso;
    logic [1:0] fase;
    logic       fase_valida;
    logic       erro_comb;
    logic       erro_timeout;

    logic [5:0] lampadas;
    logic       lamp_force = 1'b0;
    logic [5:0] lamp_val = 6'b0;
    logic [1:0] ctrl_ph;
    logic       ctrl_load = 1'b1;
    logic [1:0] load_val = 2'd0;
    logic       ack_en = 1'b0;

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  mon_on = 1'b0;
    logic [5:0] obs;

    typedef struct { int cyc; logic [5:0] v; string nm; } snap_t;
    typedef struct { int cyc; logic [1:0] f; } pulse_t;
    snap_t  snap_q[$];
    pulse_t pulse_q[$];
    pulse_t pm;

    semaforo_temporizador #(
        .CNT_W(16), .T_VERDE_2(3), .T_AMARELO_2(2),
        .T_VERDE_1(3), .T_AMARELO_1(2), .ACK_TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .clr_erro(clr_erro),
        .rua_1_vermelho(lampadas[5]), .rua_1_amarelo(lampadas[4]), .rua_1_verde(lampadas[3]),
        .rua_2_vermelho(lampadas[2]), .rua_2_amarelo(lampadas[1]), .rua_2_verde(lampadas[0]),
        .pulso(pulso), .fase(fase), .fase_valida(fase_valida),
        .erro_comb(erro_comb), .erro_timeout(erro_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Lamp order: {r1 red, r1 yellow, r1 green, r2 red, r2 yellow, r2 green}.
    function automatic logic [5:0] enc(input logic [1:0] p);
        case (p)
            2'd0: enc = 6'b100001;
            2'd1: enc = 6'b100010;
            2'd2: enc = 6'b001100;
            default: enc = 6'b010100;
        endcase
    endfunction

    // Behavioural controller: advances one phase on the edge that samples pulso.
    always @(posedge clk) begin
        if (ctrl_load) ctrl_ph <= load_val;
        else if (ack_en && pulso) ctrl_ph <= ctrl_ph + 2'd1;
    end

    assign lampadas = lamp_force ? lamp_val : enc(ctrl_ph);
    assign obs = {pulso, fase, fase_valida, erro_comb, erro_timeout};

    function automatic logic [5:0] sv(input bit p, input logic [1:0] f, input bit v,
                                      input bit c, input bit t);
        sv = {p, f, v, c, t};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic exp_snap(input string nm, input int c, input logic [5:0] v);
        snap_t e;
        e.cyc = c; e.v = v; e.nm = nm;
        snap_q.push_back(e);
    endtask

    task automatic exp_pulse(input int c, input logic [1:0] f);
        pulse_t e;
        e.cyc = c; e.f = f;
        pulse_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (pulso !== 1'b0) begin
                if (pulse_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_pulso at cycle %0d: got pulso=%b expected 0", cyc, pulso);
                end else begin
                    pm = pulse_q.pop_front();
                    chk("pulso_cycle", cyc, pm.cyc);
                    chk("pulso_fase", 32'(fase), 32'(pm.f));
                end
            end
            for (int i = snap_q.size() - 1; i >= 0; i--) begin
                if (snap_q[i].cyc == cyc) begin
                    chk(snap_q[i].nm, 32'(obs), 32'(snap_q[i].v));
                    snap_q.delete(i);
                end else if (snap_q[i].cyc < cyc) begin
                    chk({snap_q[i].nm, "_missed"}, cyc, snap_q[i].cyc);
                    snap_q.delete(i);
                end
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_reset(input logic [1:0] ph, input bit ack, output int s);
        @(negedge clk);
        rst = 1'b1; en = 1'b0; clr_erro = 1'b0; lamp_force = 1'b0;
        ctrl_load = 1'b1; load_val = ph; ack_en = ack;
        exp_snap("reset_state", cyc + 1, 6'b0);
        mon_on = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; ctrl_load = 1'b0; en = 1'b1;
        s = cyc;
    endtask

    task automatic end_test(input string nm);
        chk({nm, "_pulses_left"}, pulse_q.size(), 0);
        chk({nm, "_snaps_left"}, snap_q.size(), 0);
        pulse_q.delete();
        snap_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int p;
        int last;
        int tdw[4] = '{3, 2, 3, 2};

        // Normal rotation: three full cycles, pulse every T plus two handshake cycles.
        do_reset(2'd0, 1'b1, s);
        exp_snap("rot_first_conta", s + 1, sv(0, 2'd0, 1, 0, 0));
        p = s + 1 + tdw[0];
        last = p;
        for (int k = 0; k < 12; k++) begin
            exp_pulse(p, 2'(k % 4));
            last = p;
            p = p + 2 + tdw[(k + 1) % 4];
        end
        exp_snap("rot_espera_end", last + 1, sv(0, 2'd3, 1, 0, 0));
        wait_until(last + 2);
        end_test("rotation");

        // Illegal combination in phase 2.
        do_reset(2'd2, 1'b1, s);
        exp_snap("ilg_conta", s + 2, sv(0, 2'd2, 1, 0, 0));
        exp_snap("ilg_err", s + 3, sv(0, 2'd2, 0, 1, 0));
        exp_snap("ilg_hold", s + 12, sv(0, 2'd2, 0, 1, 0));
        wait_until(s + 2);
        lamp_force = 1'b1; lamp_val = 6'b011100;
        wait_until(s + 6);
        lamp_force = 1'b0;
        wait_until(s + 13);
        end_test("illegal");

        // No acknowledge: timeout four enabled cycles after pulso, then clear.
        do_reset(2'd0, 1'b0, s);
        exp_pulse(s + 4, 2'd0);
        exp_snap("to_before", s + 7, sv(0, 2'd0, 1, 0, 0));
        exp_snap("to_err", s + 8, sv(0, 2'd0, 0, 0, 1));
        exp_snap("to_hold", s + 9, sv(0, 2'd0, 0, 0, 1));
        exp_snap("to_cleared", s + 10, sv(0, 2'd0, 0, 0, 0));
        exp_snap("to_idle", s + 11, sv(0, 2'd0, 0, 0, 0));
        wait_until(s + 9);
        clr_erro = 1'b1; en = 1'b0;
        wait_until(s + 10);
        clr_erro = 1'b0;
        wait_until(s + 12);
        end_test("timeout");

        // Out of sequence: jump from phase 0 straight to phase 2 while waiting.
        do_reset(2'd0, 1'b0, s);
        exp_pulse(s + 4, 2'd0);
        exp_snap("seq_err", s + 5, sv(0, 2'd0, 0, 1, 0));
        exp_snap("seq_hold", s + 15, sv(0, 2'd0, 0, 1, 0));
        wait_until(s + 4);
        lamp_force = 1'b1; lamp_val = enc(2'd2);
        wait_until(s + 16);
        end_test("out_of_seq");

        // Enable stall: five disabled cycles mid-dwell of phase 1.
        do_reset(2'd1, 1'b1, s);
        exp_snap("stall_hold", s + 5, sv(0, 2'd1, 1, 0, 0));
        exp_pulse(s + 8, 2'd1);
        exp_snap("stall_espera", s + 9, sv(0, 2'd1, 1, 0, 0));
        exp_snap("stall_next", s + 11, sv(0, 2'd2, 1, 0, 0));
        exp_pulse(s + 13, 2'd2);
        wait_until(s + 2);
        en = 1'b0;
        wait_until(s + 7);
        en = 1'b1;
        wait_until(s + 14);
        end_test("stall");

        // Reset while pulso is high, then resync on phase 1.
        do_reset(2'd0, 1'b1, s);
        exp_pulse(s + 4, 2'd0);
        exp_snap("rstmid_zero", s + 5, sv(0, 2'd0, 0, 0, 0));
        exp_snap("rstmid_idle", s + 6, sv(0, 2'd0, 0, 0, 0));
        exp_snap("rstmid_idle2", s + 7, sv(0, 2'd0, 0, 0, 0));
        exp_snap("rstmid_resync", s + 8, sv(0, 2'd1, 1, 0, 0));
        exp_pulse(s + 10, 2'd1);
        wait_until(s + 4);
        rst = 1'b1;
        wait_until(s + 5);
        rst = 1'b0; en = 1'b0;
        wait_until(s + 7);
        en = 1'b1;
        wait_until(s + 11);
        end_test("reset_mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
